mem_access_initiator: RTL and testbench
=======================================

// Module: mem_access_initiator
// PURPOSE
//  Requester-side agent for the byte-wide memory controller. Accepts load/store commands from the
//  core over a valid/ready port and queues them in a small FIFO. Drives the controller's
//  wr_req/rd_req/addr/data_in sequence, honouring busy_mem/full_mem/empty_mem. Returns one response
//  (read data or error) per command, in order. Sits between the core LSU and the memory controller.
// PARAMETERS
//  CMD_DEPTH    4   command FIFO entries (power of 2, >=2)
//  RD_LAT       2   cycles rd_req is held after acceptance before data_out is sampled (>=1)
//  TIMEOUT_CYC  64  consecutive busy_mem cycles in ISSUE before a command is aborted with error
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   synchronous, active-high reset
//  cmd_valid  in   1   core command present
//  cmd_ready  out  1   FIFO can accept (= !fifo_full)
//  cmd_we     in   1   1=write, 0=read
//  cmd_addr   in   11  byte address
//  cmd_wdata  in   8   write data
//  rsp_valid  out  1   response present
//  rsp_ready  in   1   core accepts response
//  rsp_rdata  out  8   read data (0 on write or error)
//  rsp_err    out  1   command rejected (full/empty/timeout)
//  mem_addr   out  11  to controller addr
//  mem_wdata  out  8   to controller data_in
//  mem_wr_req out  1   to controller wr_req
//  mem_rd_req out  1   to controller rd_req
//  mem_rdata  in   8   from controller data_out
//  busy_mem   in   1   controller busy
//  full_mem   in   1   memory full
//  empty_mem  in   1   memory empty
//  idle       out  1   FIFO empty and FSM in IDLE
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready=1 and idle=1; FIFO emptied; FSM=IDLE; counters 0.
//  Reset mid-operation drops the in-flight command and all queued commands; no response is issued.
//  FIFO: push on cmd_valid&&cmd_ready. cmd_ready reflects the registered full flag only, so a push
//   while full is blocked even if a pop occurs in the same cycle. Pointers wrap modulo CMD_DEPTH.
//  FSM (one command in flight):
//   IDLE  : FIFO non-empty -> pop head into cmd regs; next state ISSUE.
//   ISSUE : drive mem_addr and mem_wdata; assert mem_wr_req or mem_rd_req. The two requests are
//           never high together.
//           busy_mem=1 -> stay; tmo++. When tmo reaches TIMEOUT_CYC-1 -> RESP with err=1.
//           else write && full_mem -> RESP with err=1.
//           else read && empty_mem -> RESP with err=1.
//           else write -> HOLD; read -> WAIT with lat=0. tmo is cleared on leaving ISSUE.
//   HOLD  : keep mem_wr_req, mem_addr and mem_wdata asserted for exactly 1 more cycle, so the
//           controller's buffered data reaches the RAM; then -> RESP with err=0.
//   WAIT  : keep mem_rd_req asserted while lat<RD_LAT-1; lat++ each cycle.
//           At lat==RD_LAT-1: drop mem_rd_req and capture mem_rdata the following cycle -> RESP.
//   RESP  : rsp_valid=1; rsp_rdata and rsp_err stable. rsp_ready=1 -> IDLE.
//           A queued command is popped no earlier than the cycle after the handshake.
//  Write latency from pop: 3 cycles minimum (ISSUE, HOLD, RESP).
//  Read latency from pop: RD_LAT+2 cycles minimum.
//  mem_wr_req and mem_rd_req are 0 in IDLE and RESP. mem_addr/mem_wdata hold their last value.
//  busy_mem is checked only in ISSUE. A busy_mem rising in HOLD/WAIT is ignored.
//  full_mem/empty_mem are sampled in the acceptance cycle only.
// STRUCTURE
//  Package mem_if_pkg: ADDR_W=11, DATA_W=8, state enum {IDLE,ISSUE,HOLD,WAIT,RESP},
//   command struct {we, addr, wdata}.
//  Sub-module mem_cmd_fifo: synchronous FIFO of command structs (CMD_DEPTH, full/empty flags).
//  Top level holds the FSM, the tmo and lat counters, and the response registers.
// TESTING
//  1 Write 0x5A@0x010, no busy -> wr_req high 2 cycles, addr=0x010, data=0x5A; rsp_err=0 3 cycles after pop.
//  2 Read @0x010 with mem_rdata=0x5A, RD_LAT=2 -> rd_req high 2 cycles; rsp_rdata=0x5A, rsp_err=0.
//  3 busy_mem held high 64 cycles in ISSUE -> rsp_err=1, no HOLD/WAIT entered, next command proceeds.
//  4 Write with full_mem=1 -> rsp_err=1, wr_req high 1 cycle only. Read with empty_mem=1 -> rsp_err=1, rdata=0.
//  5 Push 5 commands back-to-back with rsp_ready=0 -> cmd_ready low after 4 accepted (1 in flight + 3 queued
//    -> ready drops); responses return in order.
//  6 Assert rst during WAIT -> next cycle all mem_* outputs=0, rsp_valid=0, idle=1, no stale response.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared types and widths for the requester-side memory access agent.
package mem_if_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;

  // One command in flight moves IDLE -> ISSUE -> (HOLD | WAIT) -> RESP -> IDLE.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    HOLD  = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_e;

  // Queued core command; field order is the packing order used at the FIFO input.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  localparam int CMD_W = $bits(mem_cmd_t);

endpackage

// File: rtl/mem_cmd_fifo.sv
// Synchronous command FIFO. An entry leaves the queue when the FSM pops it, but
// its slot stays counted as used until the response is handed back (retire_i),
// so the full flag tracks every outstanding command, queued or in flight.
module mem_cmd_fifo
  import mem_if_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [CMD_W-1:0] din_i,
  input  logic             pop_i,
  output logic [CMD_W-1:0] dout_o,
  input  logic             retire_i,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [CMD_W-1:0] store_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] queued_q;
  logic [CNT_W-1:0] queued_d;
  logic [CNT_W-1:0] used_q;
  logic [CNT_W-1:0] used_d;
  logic             full_q;
  logic             empty_q;

  // Next occupancy: queued entries move with push/pop, held slots with push/retire.
  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch is inferred.
    queued_d = queued_q;
    used_d   = used_q;
    if (push_i && !pop_i) begin
      queued_d = queued_q + 1'b1;
    end else if (!push_i && pop_i) begin
      queued_d = queued_q - 1'b1;
    end
    if (push_i && !retire_i) begin
      used_d = used_q + 1'b1;
    end else if (!push_i && retire_i) begin
      used_d = used_q - 1'b1;
    end
  end

  // Pointers, counters and the registered full/empty flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      queued_q <= '0;
      used_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      queued_q <= queued_d;
      used_q   <= used_d;
      full_q   <= (used_d == CNT_FULL);
      empty_q  <= (queued_d == '0);
    end
  end

  // Entry storage.
  // NOTE: the array is not reset; the empty flag guarantees a slot is written before it is read.
  always_ff @(posedge clk) begin
    if (push_i) store_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = store_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/mem_access_initiator.sv
// Requester-side agent: queues core load/store commands and replays them one at
// a time onto the byte-wide memory controller's wr_req/rd_req interface,
// returning one in-order response (read data or error) per command.
module mem_access_initiator
  import mem_if_pkg::*;
#(
  parameter int CMD_DEPTH   = 4,
  parameter int RD_LAT      = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr_req,
  output logic              mem_rd_req,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              busy_mem,
  input  logic              full_mem,
  input  logic              empty_mem,
  output logic              idle
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int LAT_W = $clog2(RD_LAT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);
  // A read holds rd_req into WAIT only when more than one request cycle is needed.
  localparam logic RD_HOLD = (RD_LAT > 1);

  state_e            state_q;
  logic              we_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [LAT_W-1:0]  lat_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_wr_req_q;
  logic              mem_rd_req_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_retire;
  logic [CMD_W-1:0]  fifo_din;
  logic [CMD_W-1:0]  fifo_dout;
  mem_cmd_t          head;

  // Ready is the registered full flag alone, so a same-cycle retire never opens a slot early.
  assign cmd_ready   = !fifo_full;
  assign fifo_push   = cmd_valid && !fifo_full;
  assign fifo_pop    = (state_q == IDLE) && !fifo_empty;
  assign fifo_retire = (state_q == RESP) && rsp_ready;
  assign fifo_din    = {cmd_we, cmd_addr, cmd_wdata};
  assign head        = mem_cmd_t'(fifo_dout);

  mem_cmd_fifo #(
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_i   (fifo_push),
    .din_i    (fifo_din),
    .pop_i    (fifo_pop),
    .dout_o   (fifo_dout),
    .retire_i (fifo_retire),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  // Command FSM with registered controller-side and response-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      tmo_q        <= '0;
      lat_q        <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wr_req_q <= 1'b0;
      mem_rd_req_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            we_q         <= head.we;
            mem_addr_q   <= head.addr;
            mem_wdata_q  <= head.wdata;
            mem_wr_req_q <= head.we;
            mem_rd_req_q <= !head.we;
            tmo_q        <= '0;
            state_q      <= ISSUE;
          end
        end

        ISSUE: begin
          if (busy_mem) begin
            if (tmo_q == TMO_LAST) begin
              // Controller stayed busy for the whole window: abort with error.
              mem_wr_req_q <= 1'b0;
              mem_rd_req_q <= 1'b0;
              rsp_valid_q  <= 1'b1;
              rsp_err_q    <= 1'b1;
              rsp_rdata_q  <= '0;
              tmo_q        <= '0;
              state_q      <= RESP;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end else if ((we_q && full_mem) || (!we_q && empty_mem)) begin
            // Controller rejects the request in its acceptance cycle.
            mem_wr_req_q <= 1'b0;
            mem_rd_req_q <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_err_q    <= 1'b1;
            rsp_rdata_q  <= '0;
            tmo_q        <= '0;
            state_q      <= RESP;
          end else if (we_q) begin
            tmo_q   <= '0;
            state_q <= HOLD;
          end else begin
            tmo_q        <= '0;
            lat_q        <= '0;
            mem_rd_req_q <= RD_HOLD;
            state_q      <= WAIT;
          end
        end

        HOLD: begin
          // One extra wr_req cycle lets the controller's buffered byte reach the RAM.
          mem_wr_req_q <= 1'b0;
          rsp_valid_q  <= 1'b1;
          rsp_err_q    <= 1'b0;
          rsp_rdata_q  <= '0;
          state_q      <= RESP;
        end

        WAIT: begin
          if (lat_q == LAT_LAST) begin
            // rd_req is already low this cycle; the controller's data is valid now.
            mem_rd_req_q <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= mem_rdata;
            state_q      <= RESP;
          end else begin
            lat_q        <= lat_q + 1'b1;
            mem_rd_req_q <= ((lat_q + 1'b1) < LAT_LAST);
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            state_q     <= IDLE;
          end
        end

        default: begin
          mem_wr_req_q <= 1'b0;
          mem_rd_req_q <= 1'b0;
          rsp_valid_q  <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wr_req = mem_wr_req_q;
  assign mem_rd_req = mem_rd_req_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign idle       = fifo_empty && (state_q == IDLE);

endmodule

// File: tb/tb_mem_access_initiator.sv
// Self-checking bench: a tiny memory device plus an in-order response
// scoreboard whose expectations come from command-level rules (error on
// full/empty/timeout, read returns the last successfully written byte).
module tb_mem_access_initiator;
  import mem_if_pkg::*;

  localparam int CMD_DEPTH   = 4;
  localparam int RD_LAT      = 2;
  localparam int TIMEOUT_CYC = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wr_req;
  logic              mem_rd_req;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy_mem;
  logic              full_mem;
  logic              empty_mem;
  logic              idle;

  always #5 clk = ~clk;

  mem_access_initiator #(
    .CMD_DEPTH   (CMD_DEPTH),
    .RD_LAT      (RD_LAT),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wr_req (mem_wr_req),
    .mem_rd_req (mem_rd_req),
    .mem_rdata  (mem_rdata),
    .busy_mem   (busy_mem),
    .full_mem   (full_mem),
    .empty_mem  (empty_mem),
    .idle       (idle)
  );

  // Memory device contents (what the controller really holds) and the reference view.
  logic [DATA_W-1:0] dev_ram [2048];
  logic [DATA_W-1:0] ref_ram [2048];
  assign mem_rdata = dev_ram[mem_addr];

  typedef struct {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   tmo_mode = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs are stable here until the next rising edge: account for that edge, then advance.
  task automatic step();
    exp_t e;
    if (mem_wr_req || mem_rd_req) check("req_exclusive", 32'(mem_wr_req & mem_rd_req), 32'd0);
    if (mem_wr_req && !full_mem && !busy_mem) dev_ram[mem_addr] = mem_wdata;
    if (cmd_valid && cmd_ready) begin
      e.err   = tmo_mode || (cmd_we ? full_mem : empty_mem);
      e.rdata = (e.err || cmd_we) ? 8'h00 : ref_ram[cmd_addr];
      if (cmd_we && !e.err) ref_ram[cmd_addr] = cmd_wdata;
      exp_q.push_back(e);
    end
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
      end
    end
    @(negedge clk);
  endtask

  // Push one command into an idle block and trace it until its response.
  // k=0 is the cycle after the push edge (pop), k=1 the first ISSUE cycle.
  task automatic run_one(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                         output int lat, output int wr_cyc, output int rd_cyc,
                         output logic [DATA_W-1:0] rdata, output logic err);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    check("push_ready", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    lat    = -1;
    wr_cyc = 0;
    rd_cyc = 0;
    rdata  = '0;
    err    = 1'b0;
    for (int k = 0; k <= 200 && lat < 0; k++) begin
      if (mem_wr_req) wr_cyc++;
      if (mem_rd_req) rd_cyc++;
      if (mem_wr_req || mem_rd_req) check("mem_addr", 32'(mem_addr), 32'(addr));
      if (mem_wr_req) check("mem_wdata", 32'(mem_wdata), 32'(wdata));
      if (rsp_valid) begin
        lat   = k;
        rdata = rsp_rdata;
        err   = rsp_err;
      end
      step();
    end
  endtask

  task automatic drain();
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 2000 && (exp_q.size() > 0 || !idle); c++) begin
      busy_mem = ($urandom % 4) == 0;
      step();
    end
    busy_mem = 1'b0;
    check("drain_left", 32'(exp_q.size()), 32'd0);
    check("drain_idle", 32'(idle), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int                lat, wr_cyc, rd_cyc, acc, seen;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic [DATA_W-1:0] v;

    for (int i = 0; i < 2048; i++) begin
      v = 8'($urandom);
      dev_ram[i] = v;
      ref_ram[i] = v;
    end
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1; busy_mem = 1'b0; full_mem = 1'b0; empty_mem = 1'b0;
    repeat (3) step();

    // Reset state.
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp", 32'({rsp_err, rsp_rdata}), 32'd0);
    check("rst_mem_out", 32'({mem_wr_req, mem_rd_req, mem_addr, mem_wdata}), 32'd0);
    rst = 1'b0;
    step();

    // Plain write then read back.
    run_one(1'b1, 11'h010, 8'h5A, lat, wr_cyc, rd_cyc, rdata, err);
    check("wr_latency", 32'(lat), 32'd3);
    check("wr_req_cycles", 32'(wr_cyc), 32'd2);
    check("wr_no_rd_req", 32'(rd_cyc), 32'd0);
    check("wr_err", 32'(err), 32'd0);
    run_one(1'b0, 11'h010, 8'h00, lat, wr_cyc, rd_cyc, rdata, err);
    check("rd_latency", 32'(lat), 32'(RD_LAT + 2));
    check("rd_req_cycles", 32'(rd_cyc), 32'(RD_LAT));
    check("rd_data", 32'(rdata), 32'h5A);
    check("rd_err", 32'(err), 32'd0);

    // Controller busy for the whole window: abort, then the next command proceeds.
    busy_mem = 1'b1; tmo_mode = 1'b1;
    run_one(1'b1, 11'h020, 8'hC3, lat, wr_cyc, rd_cyc, rdata, err);
    check("tmo_latency", 32'(lat), 32'(TIMEOUT_CYC + 1));
    check("tmo_req_cycles", 32'(wr_cyc), 32'(TIMEOUT_CYC));
    check("tmo_err", 32'(err), 32'd1);
    busy_mem = 1'b0; tmo_mode = 1'b0;
    run_one(1'b0, 11'h010, 8'h00, lat, wr_cyc, rd_cyc, rdata, err);
    check("post_tmo_latency", 32'(lat), 32'(RD_LAT + 2));
    check("post_tmo_data", 32'(rdata), 32'h5A);

    // Controller rejects: write while full, read while empty.
    full_mem = 1'b1;
    run_one(1'b1, 11'h030, 8'h77, lat, wr_cyc, rd_cyc, rdata, err);
    check("full_latency", 32'(lat), 32'd2);
    check("full_wr_cycles", 32'(wr_cyc), 32'd1);
    check("full_err", 32'(err), 32'd1);
    full_mem = 1'b0; empty_mem = 1'b1;
    run_one(1'b0, 11'h010, 8'h00, lat, wr_cyc, rd_cyc, rdata, err);
    check("empty_rd_cycles", 32'(rd_cyc), 32'd1);
    check("empty_err", 32'(err), 32'd1);
    check("empty_rdata", 32'(rdata), 32'd0);
    empty_mem = 1'b0;

    // Back-to-back pushes with responses stalled: one in flight plus the rest queued.
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      cmd_valid = 1'b1;
      cmd_we    = 1'($urandom);
      cmd_addr  = 11'($urandom_range(0, 15));
      cmd_wdata = 8'($urandom);
      if (cmd_ready) acc++;
      step();
    end
    check("stall_accepted", 32'(acc), 32'(CMD_DEPTH));
    check("stall_ready_low", 32'(cmd_ready), 32'd0);
    drain();

    // Randomized traffic in four controller-status phases: normal, full, empty, normal.
    for (int ph = 0; ph < 4; ph++) begin
      full_mem  = (ph == 1);
      empty_mem = (ph == 2);
      for (int c = 0; c < 300; c++) begin
        cmd_valid = ($urandom % 3) != 0;
        cmd_we    = 1'($urandom);
        cmd_addr  = (($urandom % 8) == 0) ? 11'($urandom) : 11'($urandom_range(0, 15));
        cmd_wdata = 8'($urandom);
        rsp_ready = ($urandom % 4) != 0;
        busy_mem  = ($urandom % 4) == 0;
        step();
      end
      drain();
    end
    full_mem = 1'b0; empty_mem = 1'b0;

    // Reset while a read is in WAIT with more commands queued: everything is dropped.
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_we = 1'b0;
    cmd_addr = 11'h010; step();
    cmd_addr = 11'h005; step();
    cmd_addr = 11'h006; step();
    cmd_valid = 1'b0;
    check("wait_rd_req", 32'(mem_rd_req), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    step();
    check("rst_wait_mem_out", 32'({mem_wr_req, mem_rd_req, mem_addr, mem_wdata}), 32'd0);
    check("rst_wait_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_wait_idle", 32'(idle), 32'd1);
    check("rst_wait_ready", 32'(cmd_ready), 32'd1);
    rst = 1'b0;
    rsp_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid || mem_rd_req || mem_wr_req) seen++;
      step();
    end
    check("no_stale_activity", 32'(seen), 32'd0);
    check("final_idle", 32'(idle), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
